// File: rtl/if_fetch_buf.sv
// Instruction fetch buffer: issues fetch requests to instruction memory and queues
// the returned words in a small FIFO that feeds the ID stage registers.
module if_fetch_buf #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        fetch_stall_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   id_pc_q, id_pc_d, id_inst_q, id_inst_d;
    logic          id_valid_q, id_valid_d;
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_inst_q [DEPTH];

    logic issue, push, pop;
    logic unused_stall;

    assign unused_stall = ^{stall_i[5:2], stall_i[0]};

    // A back-to-back issue in WAIT needs room for both the word arriving now and the new one.
    always_comb begin
        issue = 1'b0;
        if (ce_i && !flush_i) begin
            if (state_q == IDLE) begin
                issue = (count_q < DEPTH_C);
            end else if (state_q == WAIT) begin
                issue = mem_ack_i && (count_q < LAST_C);
            end
        end
    end

    assign push = (state_q == WAIT) && mem_ack_i && !flush_i;
    assign pop  = !flush_i && !stall_i[1] && (count_q != '0);

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;

        case (state_q)
            WAIT: begin
                if (mem_ack_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end else if (flush_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ack_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: ;
        endcase

        if (issue) begin
            state_d    = WAIT;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_i;
        end

        if (flush_i) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            id_pc_d    = '0;
            id_inst_d  = '0;
            id_valid_d = 1'b0;
        end else begin
            if (pop) begin
                id_pc_d    = fifo_pc_q[rd_ptr_q];
                id_inst_d  = fifo_inst_q[rd_ptr_q];
                id_valid_d = 1'b1;
                rd_ptr_d   = rd_ptr_q + AW'(1);
            end else if (!stall_i[1]) begin
                id_pc_d    = '0;
                id_inst_d  = '0;
                id_valid_d = 1'b0;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
        end
    end

    // NOTE: FIFO storage is not reset; count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= mem_addr_q;
            fifo_inst_q[wr_ptr_q] <= mem_data_i;
        end
    end

    assign fetch_stall_o = ce_i && !issue;
    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign id_pc_o       = id_pc_q;
    assign id_inst_o     = id_inst_q;
    assign id_valid_o    = id_valid_q;

endmodule

// File: tb/tb_if_fetch_buf.sv
// Self-checking bench for if_fetch_buf: a directed vector table, hand-written corner
// sequences and a randomized run compared against a queue-based reference model.
module tb_if_fetch_buf;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        fetch_stall_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;

    always #5 clk = ~clk;

    if_fetch_buf #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .ce_i         (ce_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i),
        .fetch_stall_o(fetch_stall_o),
        .id_pc_o      (id_pc_o),
        .id_inst_o    (id_inst_o),
        .id_valid_o   (id_valid_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], ~addr[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // Reference model: a queue of fetched words plus "request outstanding / discard" flags.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t      mq[$];
    bit          m_out, m_disc;
    logic [31:0] m_addr, e_pc, e_inst;
    bit          e_valid;

    task automatic model_reset();
        mq.delete();
        m_out = 0; m_disc = 0; m_addr = '0;
        e_pc = '0; e_inst = '0; e_valid = 0;
    endtask

    function automatic bit model_issue(input bit ce, input bit fl, input bit ack);
        if (!ce || fl) return 0;
        if (!m_out) return mq.size() < DEPTH;
        return !m_disc && ack && (mq.size() < DEPTH - 1);
    endfunction

    task automatic model_clock(input bit ce, input logic [31:0] pc, input bit st1, input bit fl,
                               input bit ack, input logic [31:0] data, input bit r);
        bit     iss;
        entry_t e;
        if (r) begin
            model_reset();
            return;
        end
        iss = model_issue(ce, fl, ack);
        if (fl) begin
            mq.delete();
            e_valid = 0; e_pc = '0; e_inst = '0;
            if (m_out) begin
                if (ack) begin m_out = 0; m_disc = 0; end
                else m_disc = 1;
            end
        end else begin
            if (!st1) begin
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    e_pc = e.pc; e_inst = e.inst; e_valid = 1;
                end else begin
                    e_pc = '0; e_inst = '0; e_valid = 0;
                end
            end
            if (m_out && ack) begin
                if (!m_disc) begin
                    e.pc = m_addr; e.inst = data;
                    mq.push_back(e);
                end
                m_out = 0; m_disc = 0;
            end
        end
        if (iss) begin
            m_out = 1; m_disc = 0; m_addr = pc;
        end
    endtask

    // One clock of stimulus, entered and left at a falling edge.
    task automatic step(input bit ce, input logic [31:0] pc, input bit st1, input bit fl,
                        input bit ack, input bit r, output bit acc, output bit fs);
        rst        = r;
        ce_i       = ce;
        pc_i       = pc;
        stall_i    = 6'($urandom);
        stall_i[1] = st1;
        flush_i    = fl;
        mem_ack_i  = ack;
        mem_data_i = ack ? mem_word(mem_addr_o) : $urandom;
        #1;
        acc = !r && model_issue(ce, fl, ack);
        fs  = fetch_stall_o;
        if (!r) check("fetch_stall", fetch_stall_o, 32'(ce && !acc));
        @(posedge clk);
        model_clock(ce, pc, st1, fl, ack, mem_data_i, r);
        @(negedge clk);
        check("mem_req", mem_req_o, 32'(m_out));
        if (m_out) check("mem_addr", mem_addr_o, m_addr);
        check("id_valid", id_valid_o, 32'(e_valid));
        check("id_pc", id_pc_o, e_pc);
        check("id_inst", id_inst_o, e_inst);
    endtask

    typedef struct {
        bit          ce;
        logic [31:0] pc;
        bit          st1;
        bit          fl;
        bit          ack;
        logic [31:0] data;
        bit          x_stall;
        bit          x_req;
        logic [31:0] x_addr;
        bit          x_valid;
        logic [31:0] x_pc;
        logic [31:0] x_inst;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          acc, fs, req, ack, seen;
        logic [31:0] pc;
        logic [31:0] got[8];
        int          nv, n_fs, mcnt, mlat;

        // Zero-wait stream, stray ack in IDLE, then flush with ce high and a single fetch.
        tbl[0]  = '{1, 32'h0,   0, 0, 0, 32'h0,         0, 1, 32'h0,   0, 32'h0,   32'h0};
        tbl[1]  = '{1, 32'h4,   0, 0, 1, 32'hDEAD_0000, 0, 1, 32'h4,   0, 32'h0,   32'h0};
        tbl[2]  = '{1, 32'h8,   0, 0, 1, 32'hDEAD_0004, 0, 1, 32'h8,   1, 32'h0,   32'hDEAD_0000};
        tbl[3]  = '{1, 32'hC,   0, 0, 1, 32'hDEAD_0008, 0, 1, 32'hC,   1, 32'h4,   32'hDEAD_0004};
        tbl[4]  = '{0, 32'h0,   0, 0, 1, 32'hDEAD_000C, 0, 0, 32'h0,   1, 32'h8,   32'hDEAD_0008};
        tbl[5]  = '{0, 32'h0,   0, 0, 0, 32'h0,         0, 0, 32'h0,   1, 32'hC,   32'hDEAD_000C};
        tbl[6]  = '{0, 32'h0,   0, 0, 0, 32'h0,         0, 0, 32'h0,   0, 32'h0,   32'h0};
        tbl[7]  = '{0, 32'h0,   0, 0, 1, 32'h0BAD_0BAD, 0, 0, 32'h0,   0, 32'h0,   32'h0};
        tbl[8]  = '{0, 32'h0,   0, 0, 0, 32'h0,         0, 0, 32'h0,   0, 32'h0,   32'h0};
        tbl[9]  = '{1, 32'h100, 0, 1, 0, 32'h0,         1, 0, 32'h0,   0, 32'h0,   32'h0};
        tbl[10] = '{1, 32'h100, 0, 0, 0, 32'h0,         0, 1, 32'h100, 0, 32'h0,   32'h0};
        tbl[11] = '{0, 32'h0,   0, 0, 1, 32'h1234_5678, 0, 0, 32'h0,   0, 32'h0,   32'h0};
        tbl[12] = '{0, 32'h0,   0, 0, 0, 32'h0,         0, 0, 32'h0,   1, 32'h100, 32'h1234_5678};

        rst = 1; ce_i = 0; pc_i = '0; stall_i = '0; flush_i = 0; mem_ack_i = 0; mem_data_i = '0;
        model_reset();
        @(negedge clk);
        step(0, 0, 0, 0, 0, 1, acc, fs);
        step(1, 32'h80, 1, 1, 1, 1, acc, fs);

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            rst = 0; ce_i = tbl[i].ce; pc_i = tbl[i].pc;
            stall_i = 6'($urandom); stall_i[1] = tbl[i].st1;
            flush_i = tbl[i].fl; mem_ack_i = tbl[i].ack; mem_data_i = tbl[i].data;
            #1;
            check($sformatf("vec%0d_fetch_stall", i), fetch_stall_o, 32'(tbl[i].x_stall));
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_mem_req", i), mem_req_o, 32'(tbl[i].x_req));
            if (tbl[i].x_req) check($sformatf("vec%0d_mem_addr", i), mem_addr_o, tbl[i].x_addr);
            check($sformatf("vec%0d_id_valid", i), id_valid_o, 32'(tbl[i].x_valid));
            check($sformatf("vec%0d_id_pc", i), id_pc_o, tbl[i].x_pc);
            check($sformatf("vec%0d_id_inst", i), id_inst_o, tbl[i].x_inst);
        end

        // ID hold for 10 cycles: buffer fills to DEPTH, then drains in order
        step(0, 0, 0, 0, 0, 1, acc, fs);
        pc = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, pc, 1, 0, mem_req_o, 0, acc, fs);
            if (acc) pc += 4;
        end
        check("hold_mem_req", mem_req_o, 0);
        check("hold_fetch_stall", fetch_stall_o, 1);
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, pc, 0, 0, mem_req_o, 0, acc, fs);
            if (acc) pc += 4;
            if (id_valid_o && nv < 6) begin got[nv] = id_pc_o; nv++; end
        end
        check("hold_release_count", nv, 6);
        for (int i = 0; i < nv; i++) check($sformatf("hold_release_pc%0d", i), got[i], 32'(4 * i));

        // Flush while waiting on 0x10 with two entries queued
        step(0, 0, 0, 0, 0, 1, acc, fs);
        step(1, 32'h8,  1, 0, 0, 0, acc, fs);
        step(1, 32'hC,  1, 0, 1, 0, acc, fs);
        step(1, 32'h10, 1, 0, 1, 0, acc, fs);
        step(1, 32'h40, 1, 0, 0, 0, acc, fs);
        step(1, 32'h40, 1, 1, 0, 0, acc, fs);
        check("flush_bubble_valid", id_valid_o, 0);
        check("flush_drain_req", mem_req_o, 1);
        step(1, 32'h40, 0, 0, 0, 0, acc, fs);
        step(1, 32'h40, 0, 0, 1, 0, acc, fs);
        check("flush_drain_stall", fs, 1);
        pc = 32'h40; seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, pc, 0, 0, mem_req_o, 0, acc, fs);
            if (acc) pc += 4;
            if (id_valid_o && !seen) begin
                check("flush_first_pc", id_pc_o, 32'h40);
                check("flush_first_inst", id_inst_o, mem_word(32'h40));
                seen = 1;
            end
        end
        check("flush_first_seen", 32'(seen), 1);

        // Three-cycle memory latency: one instruction per four cycles
        step(0, 0, 0, 0, 0, 1, acc, fs);
        pc = 32'h200; mcnt = 0; n_fs = 0;
        for (int i = 0; i < 24; i++) begin
            req = mem_req_o;
            ack = req && (mcnt == 3);
            step(1, pc, 0, 0, ack, 0, acc, fs);
            if (acc) pc += 4;
            if (fs) n_fs++;
            if (ack) mcnt = 0; else if (req) mcnt++;
        end
        check("lat3_stall_cycles", n_fs, 18);

        // Reset while waiting, stray ack one cycle later
        step(0, 0, 0, 0, 0, 1, acc, fs);
        step(1, 32'h20, 0, 0, 0, 0, acc, fs);
        step(0, 0, 0, 0, 0, 1, acc, fs);
        step(0, 0, 0, 0, 1, 0, acc, fs);
        check("rst_wait_req", mem_req_o, 0);
        step(0, 0, 0, 0, 0, 0, acc, fs);
        step(0, 0, 0, 0, 0, 0, acc, fs);
        check("rst_wait_valid", id_valid_o, 0);
        check("rst_wait_pc", id_pc_o, 0);

        // Simultaneous push and pop at two entries
        step(0, 0, 0, 0, 0, 1, acc, fs);
        step(1, 32'h0, 1, 0, 0, 0, acc, fs);
        step(1, 32'h4, 1, 0, 1, 0, acc, fs);
        step(1, 32'h8, 1, 0, 1, 0, acc, fs);
        step(1, 32'hC, 0, 0, 1, 0, acc, fs);
        check("pushpop_fetch_ok", fs, 0);
        nv = 0;
        if (id_valid_o) begin got[nv] = id_pc_o; nv++; end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, mem_req_o, 0, acc, fs);
            if (id_valid_o && nv < 8) begin got[nv] = id_pc_o; nv++; end
        end
        check("pushpop_count", nv, 4);
        for (int i = 0; i < 4 && i < nv; i++) check($sformatf("pushpop_pc%0d", i), got[i], 32'(4 * i));

        // Randomized run against the reference model
        step(0, 0, 0, 0, 0, 1, acc, fs);
        pc = 32'h1000; mcnt = 0; mlat = $urandom_range(0, 3);
        for (int i = 0; i < 3000; i++) begin
            bit ce, st1, fl, r;
            req = mem_req_o;
            ack = req ? (mcnt >= mlat) : ($urandom_range(0, 15) == 0);
            ce  = ($urandom_range(0, 3) != 0);
            st1 = ($urandom_range(0, 2) == 0);
            fl  = ($urandom_range(0, 24) == 0);
            r   = ($urandom_range(0, 399) == 0);
            step(ce, pc, st1, fl, ack, r, acc, fs);
            if (acc) pc += 4;
            if (fl) pc = {$urandom_range(0, 65535), 16'h0} | 32'(4 * $urandom_range(0, 255));
            if (r || (req && ack)) begin
                mcnt = 0;
                mlat = $urandom_range(0, 3);
            end else if (req) begin
                mcnt++;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_buf.md
IF_FETCH_BUF -- requirements
Module: if_fetch_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of instruction FIFO entries (power of two, 2..8).
REQ-002 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: pc_i  in  32  fetch address from the PC register.
REQ-005 SHALL have ports: ce_i  in  1  fetch enable from the PC register; pc_i is ignored while low.
REQ-006 SHALL have ports: stall_i  in  6  pipeline stall vector; only bit 1 (ID hold) is used.
REQ-007 SHALL have ports: flush_i  in  1  discard all fetched and in-flight instructions (taken branch).
REQ-008 SHALL have ports: mem_req_o  out  1  instruction memory request, level-held until ack.
REQ-009 SHALL have ports: mem_addr_o  out  32  request address, stable while mem_req_o=1.
REQ-010 SHALL have ports: mem_ack_i  in  1  one-cycle response strobe; mem_data_i valid in that cycle.
REQ-011 SHALL have ports: mem_data_i  in  32  returned instruction word.
REQ-012 SHALL have ports: fetch_stall_o  out  1  combinational; pc_i was not accepted this cycle.
REQ-013 SHALL have ports: id_pc_o  out  32  registered PC of the instruction presented to ID.
REQ-014 SHALL have ports: id_inst_o  out  32  registered instruction presented to ID.
REQ-015 SHALL have ports: id_valid_o  out  1  registered; id_pc_o/id_inst_o hold a real instruction.

Function
REQ-016 SHALL implement states IDLE (no request), WAIT (request outstanding), DRAIN (outstanding request whose response is discarded).
REQ-017 SHALL issue (accept pc_i) when ce_i=1, flush_i=0, and either state=IDLE with count<DEPTH, or state=WAIT with mem_ack_i=1 and count<DEPTH-1.
REQ-018 SHALL on issue register mem_addr_o<=pc_i and mem_req_o<=1; next state WAIT.
REQ-019 SHALL in WAIT with mem_ack_i=1 push {mem_addr_o, mem_data_i} into the FIFO; deassert mem_req_o and go IDLE unless a new issue occurs in the same cycle (back-to-back, 1 instruction/cycle peak).
REQ-020 SHALL drive fetch_stall_o = ce_i AND NOT issue, including during flush_i.
REQ-021 SHALL when stall_i[1]=0 and FIFO non-empty pop the head into id_pc_o/id_inst_o with id_valid_o<=1.
REQ-022 SHALL when stall_i[1]=0 and FIFO empty load a bubble: id_pc_o<=0, id_inst_o<=0, id_valid_o<=0.
REQ-023 SHALL when stall_i[1]=1 hold id_pc_o/id_inst_o/id_valid_o and not pop.
REQ-024 SHALL support simultaneous push and pop in one cycle (count unchanged); pop of a just-pushed entry is not required when the FIFO was empty (1-cycle FIFO latency).
REQ-025 SHALL on flush_i=1 (priority over stall_i and mem_ack_i): empty the FIFO, load the bubble into the ID outputs, suppress issue; WAIT->DRAIN (or IDLE if mem_ack_i=1 that cycle, data discarded), IDLE stays IDLE, DRAIN stays DRAIN.
REQ-026 SHALL in DRAIN keep mem_req_o=1 until mem_ack_i, discard that data, then go IDLE.
REQ-027 SHALL ignore mem_ack_i in IDLE; the FIFO SHALL never overflow (push when count=DEPTH is impossible by REQ-017).
REQ-028 SHALL wrap FIFO read/write pointers modulo DEPTH; count width clog2(DEPTH)+1.

Reset
REQ-029 SHALL on rst=1 at a clock edge set state=IDLE, count=0, pointers=0, mem_req_o=0, mem_addr_o=0, id_pc_o=0, id_inst_o=0, id_valid_o=0; reset mid-request abandons it and a later stray ack is ignored.
REQ-030 SHALL have rst priority over flush_i, stall_i and all handshakes.

Verification
REQ-031 Zero-wait memory (ack 1 cycle after req), ce_i=1, pc 0x0,0x4,0x8 -> ID sees id_valid_o=1 with pc 0x0,0x4,0x8 and matching words, fetch_stall_o=0 steady state.
REQ-032 stall_i[1]=1 held 10 cycles, DEPTH=4 -> exactly 4 entries buffered, fetch_stall_o=1, mem_req_o=0; release -> entries popped in order, no loss/duplication.
REQ-033 flush_i pulse while WAIT on 0x10 with 2 entries queued -> outputs bubble next cycle, count=0, DRAIN; ack for 0x10 discarded; next issued pc (branch target 0x40) is the first id_valid_o instruction.
REQ-034 Memory latency 3 cycles -> mem_addr_o stable during request, one instruction per 4 cycles, fetch_stall_o=1 while waiting.
REQ-035 rst asserted in WAIT, ack arrives next cycle -> all outputs zero, FIFO empty, ack ignored.
REQ-036 Push and pop in same cycle at count=2 -> count stays 2, order preserved.
